shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter N, default 8: operand width in bits.
REQ-002 Parameter CW, default 8: width of the iteration-count bus; CW SHALL be at least clog2(N).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a multiply; sampled only in IDLE.
REQ-006 mcand  input  N  multiplicand; sampled at the accepted start edge.
REQ-007 mplier  input  N  multiplier; sampled at the accepted start edge.
REQ-008 cnt  input  CW  iteration count from the external down counter.
REQ-009 cnt_reset  output  1  loads the external counter with N-1; combinational.
REQ-010 cnt_ena  output  1  decrements the external counter; combinational.
REQ-011 busy  output  1  high while in RUN or DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 product  output  2N  result; registered.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE, encoded in 2 bits.
REQ-015 In IDLE with start=1, the block SHALL latch mcand, clear the accumulator, load mplier into the low N bits of the product register, and move to RUN at the same edge.
REQ-016 cnt_reset SHALL equal reset OR (IDLE AND start), so the counter holds N-1 in the first RUN cycle.
REQ-017 cnt_ena SHALL be 1 exactly in RUN.
REQ-018 Each RUN cycle SHALL perform one step: if product bit 0 is 1, add mcand to the upper N bits using an (N+1)-bit sum; then shift the {carry, product} value right by one.
REQ-019 The RUN cycle sampling cnt==0 SHALL be the last step; the FSM SHALL then move to DONE, giving exactly N RUN cycles.
REQ-020 In DONE, done SHALL be 1 for one cycle, followed by an unconditional move to IDLE.
REQ-021 product SHALL be final from the DONE cycle onward and SHALL hold until the next accepted start.
REQ-022 Latency SHALL be N+1 cycles from the accepted start edge to done=1.
REQ-023 start while busy=1 SHALL be ignored, including in the DONE cycle; no queuing.
REQ-024 start held high SHALL begin a new multiply on the first IDLE cycle after DONE.
REQ-025 Operands changing after the start edge SHALL NOT affect the result.
REQ-026 An operand of 0 SHALL still take the full N+1 cycles; there is no early exit.

Reset
REQ-027 When reset=1 at a clock edge, the next state SHALL be IDLE with product=0, done=0, busy=0 and the accumulator cleared.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-029 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro SHIFT_ADD_MULT_SIGNED_EN selects the arithmetic mode.
REQ-031 When SHIFT_ADD_MULT_SIGNED_EN is defined, operands and product SHALL be two's complement:
- the step SHALL sign-extend the sum instead of using the carry;
- the last step (cnt==0) SHALL subtract mcand when bit 0 is 1.
REQ-032 When SHIFT_ADD_MULT_SIGNED_EN is undefined, operands and product SHALL be unsigned, and all steps SHALL add.

Verification
REQ-033 N=8, unsigned: mcand=13, mplier=11, start for 1 cycle -> done exactly 9 cycles later, product=0x008F, busy high for 9 cycles.
REQ-034 N=8, unsigned: 0xFF x 0xFF -> product=0xFE01; 0x00 x 0xA5 -> product=0x0000 with the same 9-cycle latency.
REQ-035 N=8 with SHIFT_ADD_MULT_SIGNED_EN: 0xFF x 0xFF -> 0x0001; 0x80 x 0x7F -> 0xC080; 0x80 x 0x80 -> 0x4000.
REQ-036 start pulsed with 3x4 while RUN of 5x6 is in progress -> start ignored, product=30, single done pulse.
REQ-037 reset asserted on the 4th RUN cycle -> product=0, busy=0, no done; cnt_reset high during reset; a following start with 7x9 -> product=63.
REQ-038 start held high for 30 cycles with fixed 2x3 -> back-to-back operations, done every 10 cycles, product=6 each time.

Source files
------------

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-and-add multiplier driven by an external down counter.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands; default build is unsigned.
module shift_add_mult #(
   parameter int N  = 8,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     mcand,
   input  logic [N-1:0]     mplier,
   input  logic [CW-1:0]    cnt,
   output logic             cnt_reset,
   output logic             cnt_ena,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     mcand_q, mcand_d;
   logic [2*N-1:0]   prod_q, prod_d;
   logic [N:0]       sum;
   logic             last_step;

   // Upper half of prod_q is the accumulator; the lower half still holds unconsumed multiplier bits.
   always_comb begin
      last_step = (cnt == '0);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      sum = {prod_q[2*N-1], prod_q[2*N-1:N]};
      if (prod_q[0]) begin
         // The multiplier's top bit carries negative weight, so the final step subtracts.
         if (last_step)
            sum = {prod_q[2*N-1], prod_q[2*N-1:N]} - {mcand_q[N-1], mcand_q};
         else
            sum = {prod_q[2*N-1], prod_q[2*N-1:N]} + {mcand_q[N-1], mcand_q};
      end
`else
      sum = {1'b0, prod_q[2*N-1:N]};
      if (prod_q[0])
         sum = {1'b0, prod_q[2*N-1:N]} + {1'b0, mcand_q};
`endif
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      cnt_reset = reset;
      cnt_ena   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d   = mcand;
               prod_d    = {{N{1'b0}}, mplier};
               cnt_reset = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            cnt_ena = 1'b1;
            busy    = 1'b1;
            prod_d  = {sum, prod_q[N-1:1]};
            if (last_step)
               state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end

   assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - self-checking bench for shift_add_mult with an external down-counter model.
module tb_shift_add_mult;
   localparam int N  = 8;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [N-1:0]    mcand, mplier;
   logic [CW-1:0]   cnt;
   logic            cnt_reset, cnt_ena, busy, done;
   logic [2*N-1:0]  product;

   int tests = 0;
   int fails = 0;

   shift_add_mult #(.N(N), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .cnt(cnt), .cnt_reset(cnt_reset), .cnt_ena(cnt_ena), .busy(busy),
      .done(done), .product(product)
   );

   always #5 clk = ~clk;

   // External down counter the multiplier expects to drive.
   always_ff @(posedge clk) begin
      if (cnt_reset)
         cnt <= CW'(N - 1);
      else if (cnt_ena)
         cnt <= cnt - 1'b1;
   end

   function automatic logic [2*N-1:0] ref_mult(input logic [N-1:0] a, input logic [N-1:0] b);
      int r;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      r = int'($signed(a)) * int'($signed(b));
`else
      r = int'(a) * int'(b);
`endif
      return r[2*N-1:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full multiply: latency, busy width, result, single done pulse, and result hold.
   task automatic mult(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] exp, input string tag);
      int lat, busy_cnt;
      @(negedge clk);
      start = 1'b1; mcand = a; mplier = b;
      @(negedge clk);
      start = 1'b0; mcand = N'($urandom); mplier = N'($urandom);
      lat = 1; busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (busy) busy_cnt++;
      check({tag, "_latency"}, lat, N + 1);
      check({tag, "_busy_cycles"}, busy_cnt, N + 1);
      check({tag, "_product"}, product, exp);
      @(negedge clk);
      check({tag, "_done_pulse"}, {busy, done}, 2'b00);
      check({tag, "_hold"}, product, exp);
   endtask

   initial begin
      int dones, last_done, k;
      reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_cnt_reset", cnt_reset, 1'b1);
      check("reset_outputs", {busy, done, product}, '0);
      reset = 1'b0;

      mult(8'd13, 8'd11, 16'h008F, "13x11");
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      mult(8'hFF, 8'hFF, 16'h0001, "s_ffxff");
      mult(8'h80, 8'h7F, 16'hC080, "s_80x7f");
      mult(8'h80, 8'h80, 16'h4000, "s_80x80");
`else
      mult(8'hFF, 8'hFF, 16'hFE01, "ffxff");
`endif
      mult(8'h00, 8'hA5, 16'h0000, "0xa5");
      mult(8'hA5, 8'h00, 16'h0000, "a5x0");
      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] a, b;
         a = N'($urandom); b = N'($urandom);
         mult(a, b, ref_mult(a, b), $sformatf("rand%0d", i));
      end

      // start during RUN and during DONE must be ignored
      @(negedge clk);
      start = 1'b1; mcand = 8'd5; mplier = 8'd6;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; mcand = 8'd3; mplier = 8'd4;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (!done && k < 20) begin @(negedge clk); k++; end
      check("ign_done_seen", done, 1'b1);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      check("ign_no_second_op", dones, 0);
      check("ign_product", product, 16'd30);

      // reset on the 4th RUN cycle aborts without a done pulse
      @(negedge clk);
      start = 1'b1; mcand = 8'd5; mplier = 8'd6;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_cnt_reset", cnt_reset, 1'b1);
      @(negedge clk); reset = 1'b0;
      check("abort_state", {busy, done, product}, '0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("abort_no_done", dones, 0);
      mult(8'd7, 8'd9, 16'd63, "after_abort");

      // start held high: back-to-back operations
      @(negedge clk);
      start = 1'b1; mcand = 8'd2; mplier = 8'd3;
      dones = 0; last_done = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            check("b2b_product", product, 16'd6);
            if (last_done < 0) check("b2b_first", i, N + 1);
            else check("b2b_interval", i - last_done, N + 2);
            last_done = i;
         end
      end
      start = 1'b0;
      check("b2b_done_count", dones, 3);
      repeat (12) @(negedge clk);
      check("final_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
